// File: rtl/clock_pkg.sv
// Shared timekeeping constants for the clock chain.
// Used by seconds_counter, minutes_hours_counter and the later
// alarm/calendar stages.
package clock_pkg;

    localparam int unsigned SEC_W     = 6;
    localparam int unsigned MIN_W     = 6;
    localparam int unsigned HR_W      = 5;

    localparam int unsigned MIN_MAX   = 59;
    localparam int unsigned HR_MAX_24 = 23;
    localparam int unsigned HR_MIN_12 = 1;
    localparam int unsigned HR_MAX_12 = 12;

    // Legal hour values differ between 24h (0..23) and 12h (1..12) formats.
    function automatic logic hours_in_range(input logic [HR_W-1:0] h, input logic h12);
        if (h12)
            return (h >= HR_W'(HR_MIN_12)) && (h <= HR_W'(HR_MAX_12));
        else
            return (h <= HR_W'(HR_MAX_24));
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo counter running LO..HI with synchronous load.
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset, value returns to LO
//   inc     advance by one (wraps HI -> LO)
//   ld      load ld_val; takes priority over inc
//   ld_val  value to load (caller guarantees it is in range)
//   value   registered count
//   wrap    combinational: inc while value == HI
module mod_n_counter #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned LO    = 0,
    parameter int unsigned HI    = 59
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    logic [WIDTH-1:0] value_q, value_d;

    assign wrap  = inc && (value_q == WIDTH'(HI));
    assign value = value_q;

    always_comb begin
        value_d = value_q;
        if (ld)
            value_d = ld_val;
        else if (inc)
            value_d = wrap ? WIDTH'(LO) : value_q + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            value_q <= WIDTH'(LO);
        else
            value_q <= value_d;
    end

endmodule

// File: rtl/minutes_hours_counter.sv
// Minutes/hours timekeeping stage fed by seconds_counter's tick_minute.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   enable              count gate for tick_minute
//   tick_minute         one-cycle minute pulse
//   load, load_minutes, load_hours, load_pm   range-checked time set
//   minutes, hours, pm  current time (pm only meaningful when H12=1)
//   tick_hour           pulse after minutes wrap 59->0
//   tick_day            pulse after the midnight rollover
//   load_err            pulse after a rejected load
// H12 selects 24h (0) or 12h+AM/PM (1) hour format.
module minutes_hours_counter
    import clock_pkg::*;
#(
    parameter int unsigned H12 = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             tick_minute,
    input  logic             load,
    input  logic [MIN_W-1:0] load_minutes,
    input  logic [HR_W-1:0]  load_hours,
    input  logic             load_pm,
    output logic [MIN_W-1:0] minutes,
    output logic [HR_W-1:0]  hours,
    output logic             pm,
    output logic             tick_hour,
    output logic             tick_day,
    output logic             load_err
);

    logic count_ev;
    logic load_ok;
    logic load_bad;
    logic min_inc;
    logic min_wrap;
    logic day_wrap;
    logic [HR_W-1:0] hr_val;
    logic pm_val;

    logic tick_hour_q, tick_day_q, load_err_q;

    assign count_ev = enable && tick_minute;
    assign load_ok  = load && (load_minutes <= MIN_W'(MIN_MAX))
                           && hours_in_range(load_hours, H12 != 0);
    assign load_bad = load && !load_ok;
    // Any load request (valid or not) swallows a coincident count event.
    assign min_inc  = count_ev && !load;

    mod_n_counter #(
        .WIDTH (MIN_W),
        .LO    (0),
        .HI    (MIN_MAX)
    ) u_minutes (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (min_inc),
        .ld     (load_ok),
        .ld_val (load_minutes),
        .value  (minutes),
        .wrap   (min_wrap)
    );

    if (H12 == 0) begin : g_h24
        mod_n_counter #(
            .WIDTH (HR_W),
            .LO    (0),
            .HI    (HR_MAX_24)
        ) u_hours (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc    (min_wrap),
            .ld     (load_ok),
            .ld_val (load_hours),
            .value  (hr_val),
            .wrap   (day_wrap)
        );
        assign pm_val = 1'b0;
    end else begin : g_h12
        logic [HR_W-1:0] hr_q, hr_d;
        logic            pm_q, pm_d;

        // 12h sequence is 12,1,..,11 with pm flipping on the 11 -> 12 step,
        // so it does not fit the plain LO..HI counter.
        always_comb begin
            hr_d = hr_q;
            pm_d = pm_q;
            if (load_ok) begin
                hr_d = load_hours;
                pm_d = load_pm;
            end else if (min_wrap) begin
                if (hr_q == HR_W'(HR_MAX_12 - 1)) begin
                    hr_d = HR_W'(HR_MAX_12);
                    pm_d = !pm_q;
                end else if (hr_q == HR_W'(HR_MAX_12)) begin
                    hr_d = HR_W'(HR_MIN_12);
                end else begin
                    hr_d = hr_q + HR_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                hr_q <= HR_W'(HR_MAX_12);
                pm_q <= 1'b0;
            end else begin
                hr_q <= hr_d;
                pm_q <= pm_d;
            end
        end

        assign hr_val   = hr_q;
        assign pm_val   = pm_q;
        assign day_wrap = min_wrap && pm_q && (hr_q == HR_W'(HR_MAX_12 - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_hour_q <= 1'b0;
            tick_day_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            tick_hour_q <= min_wrap;
            tick_day_q  <= day_wrap;
            load_err_q  <= load_bad;
        end
    end

    assign hours     = hr_val;
    assign pm        = pm_val;
    assign tick_hour = tick_hour_q;
    assign tick_day  = tick_day_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_minutes_hours_counter.sv
// Bench for minutes_hours_counter: a 24h and a 12h instance share stimulus
// and are checked against a minute-of-day reference model.
module tb_minutes_hours_counter;

    logic       clk = 1'b0;
    logic       rst_n, enable, tick_minute, load, load_pm;
    logic [5:0] load_minutes;
    logic [4:0] load_hours;

    logic [5:0] m0, m1;
    logic [4:0] h0, h1;
    logic       p0, p1, th0, th1, td0, td1, le0, le1;

    int checks = 0;
    int errors = 0;

    // Reference model: minute-of-day 0..1439 per instance, plus expected pulses.
    int m24, m12;
    bit th24, td24, le24, th12, td12, le12;

    always #5 clk = ~clk;

    minutes_hours_counter #(.H12(0)) u24 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tick_minute(tick_minute),
        .load(load), .load_minutes(load_minutes), .load_hours(load_hours), .load_pm(load_pm),
        .minutes(m0), .hours(h0), .pm(p0), .tick_hour(th0), .tick_day(td0), .load_err(le0));

    minutes_hours_counter #(.H12(1)) u12 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tick_minute(tick_minute),
        .load(load), .load_minutes(load_minutes), .load_hours(load_hours), .load_pm(load_pm),
        .minutes(m1), .hours(h1), .pm(p1), .tick_hour(th1), .tick_day(td1), .load_err(le1));

    logic [14:0] obs24, obs12;
    assign obs24 = {m0, h0, p0, th0, td0, le0};
    assign obs12 = {m1, h1, p1, th1, td1, le1};

    function automatic logic [14:0] e24();
        return {6'(m24 % 60), 5'(m24 / 60), 1'b0, th24, td24, le24};
    endfunction

    function automatic logic [14:0] e12();
        int h;
        h = m12 / 60;
        return {6'(m12 % 60), 5'((h % 12 == 0) ? 12 : h % 12), (h >= 12), th12, td12, le12};
    endfunction

    // One clock edge of stimulus; model advanced from the timekeeping rules.
    task automatic cyc(input bit rst, input bit ld, input int lm, input int lh,
                       input bit lpm, input bit tk, input bit en);
        rst_n = !rst; load = ld; load_minutes = 6'(lm); load_hours = 5'(lh);
        load_pm = lpm; tick_minute = tk; enable = en;
        @(posedge clk); #1;
        th24 = 0; td24 = 0; le24 = 0; th12 = 0; td12 = 0; le12 = 0;
        if (rst) begin
            m24 = 0; m12 = 0;
        end else if (ld) begin
            if (lm <= 59 && lh <= 23) m24 = lh * 60 + lm; else le24 = 1;
            if (lm <= 59 && lh >= 1 && lh <= 12) m12 = ((lh % 12) + (lpm ? 12 : 0)) * 60 + lm;
            else le12 = 1;
        end else if (en && tk) begin
            m24++; th24 = (m24 % 60 == 0); td24 = (m24 == 1440); m24 = m24 % 1440;
            m12++; th12 = (m12 % 60 == 0); td12 = (m12 == 1440); m12 = m12 % 1440;
        end
        rst_n = 1; load = 0; tick_minute = 0;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        checks++; if (obs24 !== 15'h0) begin errors++;
            $display("FAIL reset24 got %h want %h", obs24, 15'h0); end
        checks++; if (obs12 !== {6'd0, 5'd12, 1'b0, 3'b000}) begin errors++;
            $display("FAIL reset12 got %h want %h", obs12, {6'd0, 5'd12, 1'b0, 3'b000}); end
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(1, 1, 30, 5, 1, 1, 1);
        checks++; if (obs24 !== 15'h0) begin errors++;
            $display("FAIL reset_over_load24 got %h want %h", obs24, 15'h0); end
        checks++; if (obs12 !== e12()) begin errors++;
            $display("FAIL reset_over_load12 got %h want %h", obs12, e12()); end
    endtask

    task automatic test_hour_wrap();
        int nth = 0, ntd = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 1);
            if (th0) nth++;
            if (td0) ntd++;
            checks++; if (obs24 !== e24()) begin errors++;
                $display("FAIL hour_wrap24 pulse %0d got %h want %h", i, obs24, e24()); end
            checks++; if (obs12 !== e12()) begin errors++;
                $display("FAIL hour_wrap12 pulse %0d got %h want %h", i, obs12, e12()); end
            cyc(0, 0, 0, 0, 0, 0, 1);
            if (th0) nth++;
            if (td0) ntd++;
        end
        checks++; if ({h0, m0} !== {5'd1, 6'd0}) begin errors++;
            $display("FAIL hour_wrap_time got %0d:%0d want 1:0", h0, m0); end
        checks++; if (nth != 1 || ntd != 0) begin errors++;
            $display("FAIL hour_wrap_pulses got th=%0d td=%0d want th=1 td=0", nth, ntd); end
    endtask

    task automatic test_midnight();
        cyc(0, 1, 59, 23, 0, 0, 1);
        checks++; if (obs24 !== e24()) begin errors++;
            $display("FAIL midnight_load got %h want %h", obs24, e24()); end
        cyc(0, 0, 0, 0, 0, 1, 1);
        checks++; if (obs24 !== {6'd0, 5'd0, 1'b0, 3'b110}) begin errors++;
            $display("FAIL midnight_roll got %h want %h", obs24, {6'd0, 5'd0, 1'b0, 3'b110}); end
        cyc(0, 0, 0, 0, 0, 0, 1);
        checks++; if (obs24 !== 15'h0) begin errors++;
            $display("FAIL midnight_pulse_clear got %h want %h", obs24, 15'h0); end
    endtask

    task automatic test_load_err();
        cyc(0, 1, 7, 3, 0, 0, 1);
        cyc(0, 1, 60, 5, 0, 0, 1);
        checks++; if (obs24 !== {6'd7, 5'd3, 1'b0, 3'b001}) begin errors++;
            $display("FAIL load_min60 got %h want %h", obs24, {6'd7, 5'd3, 1'b0, 3'b001}); end
        checks++; if (obs12 !== e12()) begin errors++;
            $display("FAIL load_min60_12 got %h want %h", obs12, e12()); end
        cyc(0, 1, 5, 24, 0, 1, 1);
        checks++; if (obs24 !== {6'd7, 5'd3, 1'b0, 3'b001}) begin errors++;
            $display("FAIL load_hr24 got %h want %h", obs24, {6'd7, 5'd3, 1'b0, 3'b001}); end
        cyc(0, 0, 0, 0, 0, 0, 1);
        checks++; if (le0 !== 1'b0) begin errors++;
            $display("FAIL load_err_one_cycle got %b want 0", le0); end
        cyc(0, 1, 20, 10, 0, 1, 1);
        checks++; if (obs24 !== {6'd20, 5'd10, 1'b0, 3'b000}) begin errors++;
            $display("FAIL load_with_tick got %h want %h", obs24, {6'd20, 5'd10, 1'b0, 3'b000}); end
        checks++; if (obs12 !== e12()) begin errors++;
            $display("FAIL load_with_tick12 got %h want %h", obs12, e12()); end
        cyc(0, 1, 45, 2, 1, 1, 0);
        checks++; if (obs24 !== e24() || obs12 !== e12()) begin errors++;
            $display("FAIL load_while_disabled got %h/%h want %h/%h", obs24, obs12, e24(), e12()); end
    endtask

    task automatic test_random();
        int cnt = 0;
        bit en;
        cyc(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 200; i++) begin
            en = 1'($urandom_range(0, 1));
            cyc(0, 0, 0, 0, 0, 1, en);
            if (en) cnt++;
            checks++; if (obs24 !== e24() || obs12 !== e12()) begin errors++;
                $display("FAIL random step %0d got %h/%h want %h/%h", i, obs24, obs12, e24(), e12()); end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                cyc(0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
        end
        checks++; if (int'(h0) * 60 + int'(m0) != cnt % 1440) begin errors++;
            $display("FAIL random_total got %0d want %0d", int'(h0) * 60 + int'(m0), cnt % 1440); end
    endtask

    task automatic test_h12();
        cyc(1, 0, 0, 0, 0, 0, 1);
        checks++; if (obs12 !== {6'd0, 5'd12, 1'b0, 3'b000}) begin errors++;
            $display("FAIL h12_reset got %h want %h", obs12, {6'd0, 5'd12, 1'b0, 3'b000}); end
        cyc(0, 1, 59, 11, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        checks++; if (obs12 !== {6'd0, 5'd12, 1'b1, 3'b100}) begin errors++;
            $display("FAIL h12_noon got %h want %h", obs12, {6'd0, 5'd12, 1'b1, 3'b100}); end
        checks++; if (obs24 !== e24()) begin errors++;
            $display("FAIL h12_noon_24 got %h want %h", obs24, e24()); end
        cyc(0, 1, 59, 11, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        checks++; if (obs12 !== {6'd0, 5'd12, 1'b0, 3'b110}) begin errors++;
            $display("FAIL h12_midnight got %h want %h", obs12, {6'd0, 5'd12, 1'b0, 3'b110}); end
        cyc(0, 1, 59, 12, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 1);
        checks++; if (obs12 !== {6'd0, 5'd1, 1'b0, 3'b100}) begin errors++;
            $display("FAIL h12_one got %h want %h", obs12, {6'd0, 5'd1, 1'b0, 3'b100}); end
        cyc(0, 1, 10, 0, 1, 0, 1);
        checks++; if (obs12 !== {6'd0, 5'd1, 1'b0, 3'b001}) begin errors++;
            $display("FAIL h12_hr0 got %h want %h", obs12, {6'd0, 5'd1, 1'b0, 3'b001}); end
        checks++; if (obs24 !== e24()) begin errors++;
            $display("FAIL h12_hr0_24 got %h want %h", obs24, e24()); end
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 1);
            checks++; if (obs12 !== e12()) begin errors++;
                $display("FAIL h12_run step %0d got %h want %h", i, obs12, e12()); end
        end
    endtask

    initial begin
        rst_n = 0; enable = 1; tick_minute = 0; load = 0;
        load_minutes = '0; load_hours = '0; load_pm = 0;
        m24 = 0; m12 = 0;
        th24 = 0; td24 = 0; le24 = 0; th12 = 0; td12 = 0; le12 = 0;
        test_reset();
        test_hour_wrap();
        test_midnight();
        test_load_err();
        test_random();
        test_h12();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/minutes_hours_counter.md
Name: minutes_hours_counter

Overview:
Timekeeping stage directly downstream of seconds_counter. It consumes the seconds_counter tick_minute pulse and maintains minutes and hours, in 24h or 12h+AM/PM format. It provides a synchronous time-set (load) path with range checking. It emits hour and day rollover pulses for later stages (alarm compare, calendar).

Parameters:
H12, 0, hour format select: 0 = 24h (hours 0..23), 1 = 12h (hours 1..12 plus pm flag)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  reset, synchronous, active-low
enable  input  1  count gate; tick_minute is ignored while 0
tick_minute  input  1  one-cycle pulse from seconds_counter at the 59->0 seconds wrap
load  input  1  one-cycle time-set request
load_minutes  input  6  minutes value to set
load_hours  input  5  hours value to set
load_pm  input  1  pm value to set; ignored when H12=0
minutes  output  6  current minutes, 0..59
hours  output  5  current hours, 0..23 (H12=0) or 1..12 (H12=1)
pm  output  1  0 = AM, 1 = PM; held 0 when H12=0
tick_hour  output  1  one-cycle pulse when minutes wrap 59->0
tick_day  output  1  one-cycle pulse at the midnight rollover
load_err  output  1  one-cycle pulse when a load request is rejected

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n). All outputs are registered; no combinational input-to-output paths.
- Reset (rst_n=0 at a clk edge) overrides load and tick on that same edge.
  - H12=0: minutes=0, hours=0, pm=0.
  - H12=1: minutes=0, hours=12, pm=0 (12:00 AM).
  - tick_hour=0, tick_day=0, load_err=0.
- Per-edge priority: reset > load > count.
- Count event: enable=1 and tick_minute=1 sampled at a clk edge. Each such cycle is one increment; tick_minute held high N cycles counts N times, and upstream guarantees single-cycle pulses.
- Minutes: if minutes<59, minutes+1. If minutes==59: minutes=0, tick_hour=1 on the same edge, and the hour advances.
- Hour advance, H12=0: hours<23 -> hours+1. 23 -> 0 with tick_day=1.
- Hour advance, H12=1:
  - hours==11 -> 12 and pm toggles. tick_day=1 when pm toggles 1->0 (11:59 PM -> 12:00 AM).
  - hours==12 -> 1, no pm change.
  - otherwise hours+1.
- tick_hour, tick_day and load_err are high for exactly one cycle, the cycle after the causing edge. They are 0 in every other cycle.
- Load (load=1): range check on load_minutes<=59 and load_hours.
  - Hours range: 0..23 for H12=0, 1..12 for H12=1.
  - Valid: minutes, hours and pm (H12=1 only) take the load values at the edge. No tick outputs fire. Any count event in the same cycle is dropped, not deferred.
  - Invalid: state unchanged, load_err=1 for one cycle. A count event in the same cycle is still dropped.
  - load is honoured regardless of enable.
- enable=0: state frozen, tick outputs 0. Load still works.
- Invariant: minutes and hours are never out of range in any cycle after reset.

Decomposition:
- Package clock_pkg holds:
  - widths SEC_W=6, MIN_W=6, HR_W=5
  - constants MIN_MAX=59, HR_MAX_24=23, HR_MIN_12=1, HR_MAX_12=12
  - this package is shared with seconds_counter and later alarm/calendar stages.
- One sub-module is natural: mod_n_counter, parameterised WIDTH, LO, HI.
  - Inputs: clk, rst_n, inc, ld, ld_val.
  - Outputs: value, wrap (combinational, high when inc and value==HI).
  - Instantiated for minutes and for 24h hours.
  - 12h hour and pm sequencing lives in the top level.

Test Plan:
1. H12=0: hold rst_n=0 for 2 edges, release -> 00:00, pm=0, all pulses 0. Assert rst_n=0 mid-count with load=1 on the same edge -> 00:00, load ignored.
2. H12=0, from 00:00: 60 single-cycle tick_minute pulses with enable=1 -> 01:00. tick_hour high exactly once, the cycle after the 60th pulse. tick_day never high.
3. H12=0: load 23:59, then one tick -> 00:00 with tick_hour=1 and tick_day=1 in the same single cycle.
4. Load minutes=60 hours=5 (and separately hours=24) -> load_err one cycle, time unchanged. Load with a concurrent tick at 10:20 -> 10:20, tick dropped.
5. Random enable toggling over 200 tick_minute pulses with interleaved pauses -> final minutes+60*hours equals the count of ticks sampled while enable=1 (mod 1440). Ticks during enable=0 cause no change.
6. H12=1, covering the three 12h transitions:
   - reset -> 12:00 AM
   - load 11:59 pm=0, tick -> 12:00 pm=1, tick_day=0
   - load 11:59 pm=1, tick -> 12:00 pm=0, tick_day=1
   - load 12:59 pm=0, tick -> 01:00 pm=0
   - load hours=0 -> load_err
